// File: rtl/reciprocal_newton_raphson_fixedpoint.sv
// Sequential unsigned Q(N-M).M reciprocal: leading-one normalisation, linear seed,
// then ITERATIONS Newton-Raphson steps on a single shared multiplier.
module reciprocal_newton_raphson_fixedpoint #(
    parameter int unsigned N          = 16,
    parameter int unsigned M          = 8,
    parameter int unsigned ITERATIONS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    output logic [N-1:0] reciprocal_result,
    output logic         ready
);

    localparam int unsigned F       = 2 * N;
    localparam int unsigned YW      = F + 2;
    localparam int unsigned MW      = 2 * F + 2;
    localparam int unsigned PW      = $clog2(N);
    localparam int unsigned IW      = $clog2(ITERATIONS + 1);
    localparam int unsigned CW      = F + 8;
    localparam int unsigned RW      = F + N + 2;
    localparam int unsigned SW      = $clog2(RW) + 1;
    localparam int unsigned RS_BASE = F + 1 - 2 * M;

    // Seed constants 48/17 and 32/17, rounded to F fractional bits
    localparam logic [CW-1:0] C48_FULL = ((CW'(48) << F) + CW'(8)) / CW'(17);
    localparam logic [CW-1:0] C32_FULL = ((CW'(32) << F) + CW'(8)) / CW'(17);
    localparam logic [YW-1:0] C48      = C48_FULL[YW-1:0];
    localparam logic [YW-1:0] C32      = C32_FULL[YW-1:0];
    localparam logic [YW-1:0] TWO      = YW'(1) << (F + 1);
    localparam logic [RW-1:0] MAXV     = RW'({N{1'b1}});

    typedef enum logic [2:0] {
        IDLE, NORM, SEED, ITER_A, ITER_B, DENORM, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    x_q, x_d;
    logic [PW-1:0]   p_q, p_d;
    logic [F-1:0]    d_q, d_d;
    logic [YW-1:0]   y_q, y_d;
    logic [YW-1:0]   t_q, t_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [N-1:0]    res_q, res_d;
    logic            ready_q, ready_d;

    logic [PW-1:0]   p_c;
    logic [F+N-1:0]  xs_c;
    logic [F-1:0]    d_c;
    logic [YW-1:0]   a_c, b_c;
    logic [MW-1:0]   prod_c;
    logic [YW-1:0]   prod_hi_c;
    logic [SW-1:0]   rs_c;
    logic [RW-1:0]   half_c;
    logic [RW-1:0]   rnd_c;
    logic [N-1:0]    res_c;

    // Leading-one position of the latched operand
    always_comb begin
        p_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (x_q[i]) p_c = PW'(i);
        end
    end

    assign xs_c = {x_q, {F{1'b0}}};
    assign d_c  = F'((xs_c >> p_c) >> 1);

    // Shared multiplier: C32*d in SEED, d*y in ITER_A, y*t in ITER_B
    always_comb begin
        a_c = y_q;
        b_c = YW'(d_q);
        if (state_q == SEED)   a_c = C32;
        if (state_q == ITER_B) b_c = t_q;
    end

    assign prod_c    = MW'(a_c) * MW'(b_c);
    assign prod_hi_c = YW'(prod_c >> F);

    // Denormalise by 2^(2M-p-1), round to nearest, saturate
    assign rs_c   = SW'(RS_BASE) + SW'(p_q);
    assign half_c = RW'(1) << (rs_c - SW'(1));
    assign rnd_c  = (RW'(y_q) + half_c) >> rs_c;
    assign res_c  = ((x_q == '0) || (rnd_c > MAXV)) ? {N{1'b1}} : rnd_c[N-1:0];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        p_d     = p_q;
        d_d     = d_q;
        y_d     = y_q;
        t_d     = t_q;
        iter_d  = iter_q;
        res_d   = res_q;
        ready_d = ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = X;
                    ready_d = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                p_d     = p_c;
                d_d     = d_c;
                iter_d  = '0;
                state_d = SEED;
            end
            SEED: begin
                y_d     = C48 - prod_hi_c;
                state_d = ITER_A;
            end
            ITER_A: begin
                t_d     = TWO - prod_hi_c;
                state_d = ITER_B;
            end
            ITER_B: begin
                y_d = prod_hi_c;
                if (iter_q == IW'(ITERATIONS - 1)) begin
                    state_d = DENORM;
                end else begin
                    iter_d  = iter_q + IW'(1);
                    state_d = ITER_A;
                end
            end
            DENORM: begin
                res_d   = res_c;
                ready_d = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            p_q     <= '0;
            d_q     <= '0;
            y_q     <= '0;
            t_q     <= '0;
            iter_q  <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            p_q     <= p_d;
            d_q     <= d_d;
            y_q     <= y_d;
            t_q     <= t_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
            ready_q <= ready_d;
        end
    end

    assign reciprocal_result = res_q;
    assign ready             = ready_q;

endmodule

// File: tb/tb_reciprocal_newton_raphson_fixedpoint.sv
// Bench for the fixed-point reciprocal unit: directed cases, abort, back-to-back
// and random operands against an arithmetic 2^(2M)/X reference.
module tb_reciprocal_newton_raphson_fixedpoint;

    localparam int unsigned N   = 16;
    localparam int unsigned M   = 8;
    localparam int unsigned IT  = 4;
    localparam int          LAT = 2 * IT + 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  X;
    logic [N-1:0]  reciprocal_result;
    logic          ready;

    int checks = 0;
    int errors = 0;

    reciprocal_newton_raphson_fixedpoint #(.N(N), .M(M), .ITERATIONS(IT)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .X                 (X),
        .reciprocal_result (reciprocal_result),
        .ready             (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nearest-integer 2^16/x, clipped to the output range
    function automatic int exp_round(input int x);
        int v;
        if (x == 0) return 65535;
        v = (2 * 65536 + x) / (2 * x);
        if (v > 65535) v = 65535;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Issue one start and wait (bounded) for ready; lat counts edges after acceptance
    task automatic run_op(input logic [N-1:0] x, output logic [N-1:0] r, output int lat);
        @(negedge clk);
        start = 1'b1;
        X     = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        X     = N'($urandom);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop x=%0d got=%0b want=0", x, ready);
        end
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = reciprocal_result;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%0b want=0", ready);
        end
        checks++;
        if (reciprocal_result !== '0) begin
            errors++;
            $display("FAIL reset_result got=%0d want=0", reciprocal_result);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unity();
        logic [N-1:0] r;
        int lat;
        run_op(16'd256, r, lat);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL unity_latency got=%0d want=%0d", lat, LAT);
        end
        checks++;
        if (r !== 16'd256) begin
            errors++;
            $display("FAIL unity_result got=%0d want=256", r);
        end
    endtask

    task automatic test_directed();
        int xs [9] = '{128, 127, 266, 123, 1, 65525, 255, 1000, 3};
        logic [N-1:0] r;
        int lat;
        int e;
        foreach (xs[i]) begin
            run_op(N'(xs[i]), r, lat);
            e = exp_round(xs[i]);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL directed_latency x=%0d got=%0d want=%0d", xs[i], lat, LAT);
            end
            checks++;
            if (iabs(int'(r) - e) > 1) begin
                errors++;
                $display("FAIL directed_result x=%0d got=%0d want=%0d(+-1)", xs[i], r, e);
            end
        end
    endtask

    task automatic test_zero();
        logic [N-1:0] r;
        int lat;
        run_op('0, r, lat);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL zero_latency got=%0d want=%0d", lat, LAT);
        end
        checks++;
        if (r !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_result got=%0h want=ffff", r);
        end
    endtask

    task automatic test_abort();
        logic [N-1:0] r;
        int lat;
        int bad;
        @(negedge clk);
        start = 1'b1;
        X     = 16'd777;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || reciprocal_result !== '0) begin
            errors++;
            $display("FAIL abort_async ready=%0b result=%0d want ready=0 result=0",
                     ready, reciprocal_result);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_completion ready_high_cycles=%0d want=0", bad);
        end
        run_op(16'd512, r, lat);
        checks++;
        if (lat != LAT || r !== 16'd128) begin
            errors++;
            $display("FAIL abort_recover latency=%0d result=%0d want latency=%0d result=128",
                     lat, r, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] r;
        int lat;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_precondition ready=%0b want=1", ready);
        end
        run_op(16'd640, r, lat);
        checks++;
        if (lat != LAT || iabs(int'(r) - exp_round(640)) > 1) begin
            errors++;
            $display("FAIL b2b_result latency=%0d result=%0d want latency=%0d result=%0d",
                     lat, r, LAT, exp_round(640));
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] xv;
        int lat;
        real ideal;
        real err;
        for (int n = 0; n < 40; n++) begin
            xv = N'($urandom_range(65535, 1));
            run_op(xv, r, lat);
            ideal = 256.0 / real'(xv);
            if (ideal > 65535.0 / 256.0) ideal = 65535.0 / 256.0;
            err = real'(r) / 256.0 - ideal;
            if (err < 0.0) err = -err;
            checks++;
            if (lat != LAT || err > 0.05) begin
                errors++;
                $display("FAIL random x=%0d result=%0d latency=%0d err=%f want err<=0.05 latency=%0d",
                         xv, r, lat, err, LAT);
            end
            if (n % 8 == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    X = N'($urandom);
                    @(posedge clk);
                    #1;
                    checks++;
                    if (ready !== 1'b1 || reciprocal_result !== r) begin
                        errors++;
                        $display("FAIL hold_stable ready=%0b result=%0d want ready=1 result=%0d",
                                 ready, reciprocal_result, r);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_directed();
        test_zero();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
